// File: rtl/cpu_run_ctrl.sv
// cpu_run_ctrl
// Owns the CPU core reset and supervises a single program run. After an
// accepted start the core is held in reset for RST_CYCLES cycles and then
// released. The run ends on cpu_done, timeout, hang (PC stuck on itself)
// or abort. Status, RUN-cycle count, PC-change count and final PC are kept
// until the next accepted start.
//
// Ports
//   clk          in   rising-edge clock
//   reset        in   asynchronous active-low reset
//   start        in   begin a run (IDLE only)
//   abort        in   end a run early (HOLD/RUN only)
//   cpu_pc       in   current PC from the core
//   cpu_next_pc  in   next PC from the core
//   cpu_done     in   core completion flag
//   cpu_reset    out  active-high reset to the core
//   busy         out  high in HOLD and RUN
//   finished     out  one-cycle pulse in END
//   status       out  0 none, 1 done, 2 timeout, 3 hang, 4 abort
//   cycle_count  out  RUN cycles of the last/current run
//   pc_changes   out  RUN cycles where cpu_pc differed from the previous cycle
//   final_pc     out  cpu_pc on the terminating cycle
//
// state | meaning
// IDLE  | core in reset, waiting for start
// HOLD  | core in reset for RST_CYCLES cycles after start
// RUN   | core released, watching done/timeout/hang/abort
// END   | one-cycle finished pulse, core back in reset

module cpu_run_ctrl #(
   parameter int unsigned RST_CYCLES  = 2,
   parameter int unsigned TIMEOUT     = 25000,
   parameter int unsigned HANG_CYCLES = 16,
   parameter int unsigned CNT_W       = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic             abort,
   input  logic [31:0]      cpu_pc,
   input  logic [31:0]      cpu_next_pc,
   input  logic             cpu_done,
   output logic             cpu_reset,
   output logic             busy,
   output logic             finished,
   output logic [2:0]       status,
   output logic [CNT_W-1:0] cycle_count,
   output logic [CNT_W-1:0] pc_changes,
   output logic [31:0]      final_pc
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_HOLD = 2'd1,
      ST_RUN  = 2'd2,
      ST_END  = 2'd3
   } state_t;

   localparam logic [2:0] STAT_NONE    = 3'd0;
   localparam logic [2:0] STAT_DONE    = 3'd1;
   localparam logic [2:0] STAT_TIMEOUT = 3'd2;
   localparam logic [2:0] STAT_HANG    = 3'd3;
   localparam logic [2:0] STAT_ABORT   = 3'd4;

   // Terminal-count values compared against the registered counters, so the
   // run ends on the TIMEOUT-th / HANG_CYCLES-th cycle rather than one later.
   localparam logic [CNT_W-1:0] TIMEOUT_TC = CNT_W'(TIMEOUT - 1);
   localparam logic [CNT_W-1:0] HANG_TC    = CNT_W'(HANG_CYCLES - 1);
   localparam logic [7:0]       HOLD_LOAD  = 8'(RST_CYCLES);
   localparam logic [CNT_W-1:0] CNT_MAX    = '1;

   state_t           state_q;
   state_t           state_nxt;
   logic [2:0]       term_status;
   logic [7:0]       hold_cnt_q;
   logic [CNT_W-1:0] stall_cnt_q;
   logic [31:0]      prev_pc_q;
   logic             stall_now;
   logic             timeout_hit;
   logic             hang_hit;

   assign stall_now   = (cpu_pc == cpu_next_pc);
   assign timeout_hit = (cycle_count == TIMEOUT_TC);
   assign hang_hit    = stall_now && (stall_cnt_q == HANG_TC);

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (v == CNT_MAX) ? v : v + 1'b1;
   endfunction

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_nxt;
      end
   end

   always_comb begin
      state_nxt   = state_q;
      term_status = STAT_NONE;
      case (state_q)
         ST_IDLE: begin
            if (start) state_nxt = ST_HOLD;
         end
         ST_HOLD: begin
            if (abort) begin
               term_status = STAT_ABORT;
               state_nxt   = ST_END;
            end else if (hold_cnt_q <= 8'd1) begin
               // Last HOLD cycle: the count reaches 0 on this edge.
               state_nxt = ST_RUN;
            end
         end
         ST_RUN: begin
            if (abort)            term_status = STAT_ABORT;
            else if (cpu_done)    term_status = STAT_DONE;
            else if (timeout_hit) term_status = STAT_TIMEOUT;
            else if (hang_hit)    term_status = STAT_HANG;
            if (term_status != STAT_NONE) state_nxt = ST_END;
         end
         ST_END: begin
            state_nxt = ST_IDLE;
         end
         default: begin
            state_nxt = ST_IDLE;
         end
      endcase
   end

   // Outputs are registered from the next state so they line up with state_q.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cpu_reset   <= 1'b1;
         busy        <= 1'b0;
         finished    <= 1'b0;
         status      <= STAT_NONE;
         cycle_count <= '0;
         pc_changes  <= '0;
         final_pc    <= '0;
         hold_cnt_q  <= '0;
         stall_cnt_q <= '0;
         prev_pc_q   <= '0;
      end else begin
         cpu_reset <= (state_nxt != ST_RUN);
         busy      <= (state_nxt == ST_HOLD) || (state_nxt == ST_RUN);
         finished  <= (state_nxt == ST_END);

         case (state_q)
            ST_IDLE: begin
               if (start) begin
                  hold_cnt_q  <= HOLD_LOAD;
                  cycle_count <= '0;
                  pc_changes  <= '0;
                  stall_cnt_q <= '0;
                  status      <= STAT_NONE;
               end
            end
            ST_HOLD: begin
               if (hold_cnt_q != 8'd0) hold_cnt_q <= hold_cnt_q - 8'd1;
               if (term_status != STAT_NONE) begin
                  status   <= term_status;
                  final_pc <= cpu_pc;
               end
            end
            ST_RUN: begin
               cycle_count <= sat_inc(cycle_count);
               stall_cnt_q <= stall_now ? sat_inc(stall_cnt_q) : '0;
               // cycle_count is still 0 on the first RUN cycle, where there is
               // no previous PC to compare against.
               if ((cycle_count != '0) && (cpu_pc != prev_pc_q)) begin
                  pc_changes <= sat_inc(pc_changes);
               end
               prev_pc_q <= cpu_pc;
               if (term_status != STAT_NONE) begin
                  status   <= term_status;
                  final_pc <= cpu_pc;
               end
            end
            default: begin
            end
         endcase
      end
   end

endmodule

// File: tb/tb_cpu_run_ctrl.sv
module tb_cpu_run_ctrl;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic        abort;
   logic [31:0] cpu_pc;
   logic [31:0] cpu_next_pc;
   logic        cpu_done;
   logic        cpu_reset;
   logic        busy;
   logic        finished;
   logic [2:0]  status;
   logic [31:0] cycle_count;
   logic [31:0] pc_changes;
   logic [31:0] final_pc;

   int errors = 0;
   int checks = 0;

   cpu_run_ctrl #(
      .RST_CYCLES (2),
      .TIMEOUT    (20),
      .HANG_CYCLES(4),
      .CNT_W      (32)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .start      (start),
      .abort      (abort),
      .cpu_pc     (cpu_pc),
      .cpu_next_pc(cpu_next_pc),
      .cpu_done   (cpu_done),
      .cpu_reset  (cpu_reset),
      .busy       (busy),
      .finished   (finished),
      .status     (status),
      .cycle_count(cycle_count),
      .pc_changes (pc_changes),
      .final_pc   (final_pc)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // start on one edge, then the two HOLD edges; leaves the DUT on RUN cycle 1
   task automatic begin_run();
      start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      tick();
   endtask

   task automatic run_cycle(input logic [31:0] pc, input logic [31:0] npc, input logic done);
      cpu_pc      = pc;
      cpu_next_pc = npc;
      cpu_done    = done;
      tick();
      cpu_done    = 1'b0;
   endtask

   initial begin
      reset       = 1'b0;
      start       = 1'b0;
      abort       = 1'b0;
      cpu_pc      = 32'h0;
      cpu_next_pc = 32'h4;
      cpu_done    = 1'b0;

      // reset values
      tick();
      tick();
      check("rst_cpu_reset", cpu_reset, 1);
      check("rst_busy", busy, 0);
      check("rst_finished", finished, 0);
      check("rst_status", status, 0);
      check("rst_cycle_count", cycle_count, 0);
      check("rst_final_pc", final_pc, 0);
      #2 reset = 1'b1;
      tick();
      check("idle_cpu_reset", cpu_reset, 1);

      // normal completion: cpu_reset high through t0+2, low at t0+3
      start = 1'b1;
      tick();
      start = 1'b0;
      check("norm_hold1_cpu_reset", cpu_reset, 1);
      check("norm_hold1_busy", busy, 1);
      tick();
      check("norm_hold2_cpu_reset", cpu_reset, 1);
      tick();
      check("norm_run_cpu_reset", cpu_reset, 0);
      check("norm_run_busy", busy, 1);
      for (int i = 1; i <= 9; i++) run_cycle(32'(4 * i), 32'(4 * i + 4), 1'b0);
      check("norm_c9_finished", finished, 0);
      run_cycle(32'h40, 32'h44, 1'b1);
      check("norm_end_finished", finished, 1);
      check("norm_end_cpu_reset", cpu_reset, 1);
      check("norm_end_busy", busy, 0);
      check("norm_status", status, 1);
      check("norm_cycle_count", cycle_count, 10);
      check("norm_final_pc", final_pc, 32'h40);
      check("norm_pc_changes", pc_changes, 9);
      tick();
      check("norm_idle_finished", finished, 0);
      check("norm_idle_status_hold", status, 1);
      check("norm_idle_count_hold", cycle_count, 10);

      // timeout, PC +4 every cycle
      begin_run();
      check("to_status_cleared", status, 0);
      for (int i = 1; i <= 19; i++) run_cycle(32'(4 * i), 32'(4 * i + 4), 1'b0);
      check("to_c19_busy", busy, 1);
      run_cycle(32'd80, 32'd84, 1'b0);
      check("to_finished", finished, 1);
      check("to_status", status, 2);
      check("to_cycle_count", cycle_count, 20);
      check("to_pc_changes", pc_changes, 19);
      check("to_final_pc", final_pc, 80);
      tick();

      // hang: pc == next_pc == 0x100 from RUN cycle 5
      begin_run();
      for (int i = 1; i <= 4; i++) run_cycle(32'(4 * i), 32'(4 * i + 4), 1'b0);
      for (int i = 5; i <= 7; i++) run_cycle(32'h100, 32'h100, 1'b0);
      check("hang_c7_busy", busy, 1);
      run_cycle(32'h100, 32'h100, 1'b0);
      check("hang_finished", finished, 1);
      check("hang_status", status, 3);
      check("hang_cycle_count", cycle_count, 8);
      check("hang_final_pc", final_pc, 32'h100);
      check("hang_pc_changes", pc_changes, 4);
      tick();

      // abort in HOLD: core never leaves reset
      start = 1'b1;
      tick();
      start = 1'b0;
      abort = 1'b1;
      tick();
      abort = 1'b0;
      check("ab_hold_status", status, 4);
      check("ab_hold_finished", finished, 1);
      check("ab_hold_cpu_reset", cpu_reset, 1);
      check("ab_hold_cycle_count", cycle_count, 0);
      tick();
      check("ab_hold_idle_cpu_reset", cpu_reset, 1);
      check("ab_hold_idle_busy", busy, 0);

      // abort and cpu_done together on RUN cycle 2
      begin_run();
      run_cycle(32'h4, 32'h8, 1'b0);
      abort = 1'b1;
      run_cycle(32'h8, 32'hc, 1'b1);
      abort = 1'b0;
      check("ab_done_status", status, 4);
      check("ab_done_cycle_count", cycle_count, 2);
      check("ab_done_final_pc", final_pc, 32'h8);
      tick();

      // cpu_done on the timeout cycle wins
      begin_run();
      for (int i = 1; i <= 19; i++) run_cycle(32'(4 * i), 32'(4 * i + 4), 1'b0);
      run_cycle(32'd80, 32'd84, 1'b1);
      check("done_to_status", status, 1);
      check("done_to_cycle_count", cycle_count, 20);
      tick();

      // start during RUN ignored, then mid-run reset
      begin_run();
      run_cycle(32'h4, 32'h8, 1'b0);
      start = 1'b1;
      run_cycle(32'h8, 32'hc, 1'b0);
      start = 1'b0;
      run_cycle(32'hc, 32'h10, 1'b0);
      check("ign_start_busy", busy, 1);
      check("ign_start_cpu_reset", cpu_reset, 0);
      check("ign_start_cycle_count", cycle_count, 3);
      check("ign_start_pc_changes", pc_changes, 2);
      #2 reset = 1'b0;
      #1;
      check("mid_rst_cpu_reset", cpu_reset, 1);
      check("mid_rst_busy", busy, 0);
      check("mid_rst_finished", finished, 0);
      check("mid_rst_status", status, 0);
      check("mid_rst_cycle_count", cycle_count, 0);
      check("mid_rst_pc_changes", pc_changes, 0);
      check("mid_rst_final_pc", final_pc, 0);
      tick();
      check("mid_rst_held_cpu_reset", cpu_reset, 1);
      #2 reset = 1'b1;
      tick();

      // fresh run after reset
      begin_run();
      check("fresh_cycle_count", cycle_count, 0);
      for (int i = 1; i <= 4; i++) run_cycle(32'(32'h200 + 4 * i), 32'(32'h204 + 4 * i), 1'b0);
      run_cycle(32'h214, 32'h218, 1'b1);
      check("fresh_status", status, 1);
      check("fresh_cycle_count_end", cycle_count, 5);
      check("fresh_pc_changes", pc_changes, 4);
      check("fresh_final_pc", final_pc, 32'h214);
      tick();
      check("fresh_idle_busy", busy, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/cpu_run_ctrl.md
# cpu_run_ctrl

Hardware run controller that owns the CPU core's reset and supervises one program execution, replacing the simulation-only sequencing done in benches. It holds the core in reset for a fixed number of cycles after `start`, releases it, and watches `cpu_done`, `cpu_pc` and `cpu_next_pc`. It ends the run on completion, timeout, hang or abort, and reports status, cycle count, final PC and PC-change count. It sits between the SoC/bench top and the control-unit core.

## Interface
- `RST_CYCLES`, 2: number of cycles the core is held in reset after `start`; range 1..255.
- `TIMEOUT`, 25000: maximum number of RUN cycles before the run is declared a timeout; must be ≥1.
- `HANG_CYCLES`, 16: number of consecutive cycles with `cpu_pc == cpu_next_pc` that declares a hang; must be ≥1.
- `CNT_W`, 32: width of the counters.
- `clk` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `start` in 1: one-cycle request to begin a run; honoured only in IDLE.
- `abort` in 1: terminates a run in progress; honoured in HOLD and RUN.
- `cpu_pc` in 32: current PC from the core.
- `cpu_next_pc` in 32: next PC from the core.
- `cpu_done` in 1: core completion flag.
- `cpu_reset` out 1: active-high reset to the core.
- `busy` out 1: high in HOLD and RUN.
- `finished` out 1: one-cycle pulse in END.
- `status` out 3: 0 NONE, 1 DONE, 2 TIMEOUT, 3 HANG, 4 ABORT.
- `cycle_count` out CNT_W: number of RUN cycles in the last or current run.
- `pc_changes` out CNT_W: number of RUN cycles in which `cpu_pc` differed from its previous-cycle value.
- `final_pc` out 32: `cpu_pc` sampled on the terminating cycle.

## Operation
- The FSM has four states: IDLE, HOLD, RUN, END. All outputs are registered.
- State outputs:
  - IDLE: `cpu_reset`=1, `busy`=0.
  - HOLD: `cpu_reset`=1, `busy`=1.
  - RUN: `cpu_reset`=0, `busy`=1.
  - END: `cpu_reset`=1, `busy`=0, `finished`=1.
- IDLE→HOLD on `start`=1:
  - Load the hold counter with `RST_CYCLES`.
  - Clear `cycle_count`, `pc_changes`, the stall counter and `status`. `final_pc` holds its value.
- HOLD:
  - Decrement the hold counter each cycle; go to RUN when it reaches 0. The core therefore sees exactly `RST_CYCLES` cycles of HOLD reset after the `start` edge.
  - `abort` in HOLD → END with status ABORT.
- RUN, evaluated every cycle:
  - `cycle_count` increments by 1, including on the terminating cycle.
  - Stall counter: increments if `cpu_pc == cpu_next_pc`, otherwise clears to 0.
  - `pc_changes` increments if `cpu_pc` differs from the registered previous `cpu_pc`. This comparison is not made on the first RUN cycle.
  - Termination priority, highest first:
    - `abort` → ABORT.
    - `cpu_done` → DONE.
    - registered `cycle_count == TIMEOUT-1` → TIMEOUT.
    - stall counter `== HANG_CYCLES-1` and the current cycle also stalls → HANG.
  - On termination: go to END, latch `status`, and latch `final_pc` = `cpu_pc`.
- END: always returns to IDLE on the next cycle.
- `start` is ignored in HOLD, RUN and END. `abort` is ignored in IDLE and END.
- Counters saturate at all-ones and do not wrap.
- Asynchronous `reset`=0, at any time including mid-run:
  - state=IDLE, `cpu_reset`=1, `busy`=0, `finished`=0, `status`=0.
  - All counters 0, `final_pc`=0.

## Timing
- `start` sampled at edge t0:
  - HOLD during cycles t0+1 .. t0+`RST_CYCLES`.
  - `cpu_reset` falls at t0+`RST_CYCLES`+1, which is the first RUN cycle.
- `cpu_done` sampled high on the k-th RUN cycle:
  - END on the next cycle, with `cpu_reset`=1 and `finished`=1.
  - `status`=DONE, `cycle_count`=k.
  - IDLE one cycle after END.
- Timeout: a run with no `cpu_done` ends with `cycle_count`=`TIMEOUT`.
- Hang: detected on the `HANG_CYCLES`-th consecutive stalled RUN cycle.
- Simultaneous events resolve by the termination priority above. `cpu_done` together with timeout on the same cycle → DONE.
- `status`, `cycle_count`, `pc_changes` and `final_pc` remain stable from END until the next accepted `start`.

## Test plan
- **Reset values:** assert `reset`=0 → `cpu_reset`=1, `busy`=0, `status`=0, `cycle_count`=0, `final_pc`=0.
- **Normal completion:** `RST_CYCLES`=2; `start` at t0 → `cpu_reset`=1 through t0+2 and 0 at t0+3. Raise `cpu_done` on RUN cycle 10 with `cpu_pc`=0x40 → one-cycle `finished`, `status`=1, `cycle_count`=10, `final_pc`=0x40.
- **Timeout:** `TIMEOUT`=20, `cpu_done` held at 0, PC incrementing by 4 → `status`=2, `cycle_count`=20, `pc_changes`=19.
- **Hang:** `HANG_CYCLES`=4, `cpu_pc`=`cpu_next_pc`=0x100 held from RUN cycle 5 → `status`=3 at RUN cycle 8.
- **Abort and priority:** `abort` in HOLD → `status`=4 and the core never leaves reset. `abort` and `cpu_done` on the same RUN cycle → `status`=4. `cpu_done` on cycle `TIMEOUT` → `status`=1.
- **Mid-run reset and ignored start:** `reset`=0 mid-RUN → immediate IDLE with all outputs at reset values. `start` pulsed during RUN has no effect; the next `start` in IDLE begins a fresh run with counters cleared.
